adc_sample_ctrl: RTL

ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_sclk_gen.sv | 72 +++++++
 rtl/adc_sample_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample controller: frame geometry,
// parameter defaults and the controller state encoding.
package adc_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned LEAD_ZEROS = 4;

    localparam int unsigned DIV_HALF_DEFAULT = 25;
    localparam int unsigned QUIET_DEFAULT    = 50;
    localparam int unsigned PERIOD_DEFAULT   = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider for the ADC serial interface.
// While en_i is high, SCLK toggles every DIV_HALF clocks starting with a
// falling edge, and stops high after FRAME_BITS rising edges.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   en_i           - run the divider (held high for the whole conversion)
//   sclk_o         - registered serial clock, idle high
//   rise_tick_o    - high in the clk cycle whose closing edge raises SCLK
//   fall_tick_o    - high in the clk cycle whose closing edge lowers SCLK
//   done_o         - all FRAME_BITS rising edges have been produced
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int unsigned DIV_HALF = DIV_HALF_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic done_o
);

    localparam logic [7:0] DIV_LAST  = 8'(DIV_HALF - 1);
    localparam logic [4:0] EDGE_LAST = 5'(FRAME_BITS);

    logic [7:0] div_q, div_d;
    logic [4:0] rises_q, rises_d;
    logic       sclk_q, sclk_d;
    logic       tick;

    always_comb begin
        done_o      = (rises_q == EDGE_LAST);
        // Gating with done keeps SCLK parked high once the frame is complete,
        // which matters when DIV_HALF is 1.
        tick        = en_i && !done_o && (div_q == DIV_LAST);
        rise_tick_o = tick && !sclk_q;
        fall_tick_o = tick && sclk_q;
        sclk_d      = sclk_q;
        div_d       = div_q;
        rises_d     = rises_q;
        if (!en_i) begin
            sclk_d  = 1'b1;
            div_d   = '0;
            rises_d = '0;
        end else if (tick) begin
            div_d  = '0;
            sclk_d = !sclk_q;
            if (!sclk_q) begin
                rises_d = rises_q + 5'd1;
            end
        end else if (!done_o) begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q  <= 1'b1;
            div_q   <= '0;
            rises_q <= '0;
        end else begin
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            rises_q <= rises_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic sampling controller for a 16-bit-frame serial ADC
// (4 leading zeros followed by 12 data bits, MSB first).
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   en            - level enable for periodic conversions
//   sdata         - serial ADC data
//   SCLK, CS      - ADC serial clock (idle high) and chip select (active low)
//   sample        - last completed conversion, held
//   sample_valid  - 1-clk pulse when sample updates
//   frame_err     - 1-clk pulse with sample_valid when a leading bit was 1
//   overrun       - 1-clk pulse when a period elapsed during a frame/quiet
//   busy          - high while CS is low
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned DIV_HALF = DIV_HALF_DEFAULT,
    parameter int unsigned QUIET    = QUIET_DEFAULT,
    parameter int unsigned PERIOD   = PERIOD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sdata,
    output logic                 SCLK,
    output logic                 CS,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [15:0] PER_LAST   = 16'(PERIOD - 1);
    localparam logic [9:0]  QUIET_LAST = 10'(QUIET - 1);

    state_e                  state_q, state_d;
    logic [15:0]             pcnt_q, pcnt_d;
    logic [9:0]              qcnt_q, qcnt_d;
    logic                    pend_q, pend_d;
    logic [FRAME_BITS-1:0]   shift_q;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic [DATA_BITS-1:0]    sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;

    logic rise_tick, sclk_done, pcnt_at_end;
    // Falling ticks are not needed here: data is captured on rising edges.
    logic fall_tick_unused;

    adc_sclk_gen #(
        .DIV_HALF(DIV_HALF)
    ) u_sclk_gen (
        .clk_i      (clk),
        .rst_ni     (reset),
        .en_i       (state_q == ST_CONV),
        .sclk_o     (SCLK),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick_unused),
        .done_o     (sclk_done)
    );

    always_comb begin
        pcnt_at_end = (pcnt_q == PER_LAST);
        state_d     = state_q;
        pcnt_d      = pcnt_at_end ? pcnt_q : pcnt_q + 16'd1;
        qcnt_d      = '0;
        pend_d      = pend_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;

        // A period that elapses mid-frame or mid-quiet is flagged once;
        // pend_q stays set until the next frame start.
        if ((state_q == ST_CONV || state_q == ST_QUIET) && pcnt_at_end && !pend_q) begin
            ovr_d  = 1'b1;
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                pcnt_d = '0;
                if (en) state_d = ST_CONV;
            end
            ST_CONV: begin
                if (sclk_done) begin
                    state_d  = ST_QUIET;
                    sample_d = shift_q[DATA_BITS-1:0];
                    valid_d  = 1'b1;
                    ferr_d   = |shift_q[FRAME_BITS-1 -: LEAD_ZEROS];
                end
            end
            ST_QUIET: begin
                qcnt_d = qcnt_q + 10'd1;
                if (qcnt_q == QUIET_LAST) begin
                    // After an overrun the period has already expired, so the
                    // next frame follows the quiet gap directly.
                    if (!en)              state_d = ST_IDLE;
                    else if (pcnt_at_end) state_d = ST_CONV;
                    else                  state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en)              state_d = ST_IDLE;
                else if (pcnt_at_end) state_d = ST_CONV;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_CONV && state_q != ST_CONV) begin
            pcnt_d = '0;
            pend_d = 1'b0;
        end

        cs_d   = (state_d != ST_CONV);
        busy_d = (state_d == ST_CONV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            qcnt_q   <= '0;
            pend_q   <= 1'b0;
            shift_q  <= '0;
            cs_q     <= 1'b1;
            busy_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            qcnt_q   <= qcnt_d;
            pend_q   <= pend_d;
            if (rise_tick) shift_q <= {shift_q[FRAME_BITS-2:0], sdata};
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign CS           = cs_q;
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;

endmodule
